// File: rtl/cond_ctrl_pipe.sv
// Registered decode stage: evaluates cond against NZCV and emits one control word
// per accepted instruction, stalling conditional ops until their flags are final.
module cond_ctrl_pipe #(
    parameter int          ALU_OP_W = 4,
    parameter int          PEND_MAX = 3,
    parameter int          FWD_EN   = 1,
    parameter logic [3:0]  NZCV_RST = 4'b0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [11:0]         opfunc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                reg_write,
    output logic [1:0]          alu_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                mem_to_reg,
    output logic                mem_write,
    output logic                pc_src,
    output logic                update_nzcv,
    output logic                link,
    output logic                cond_fail,
    input  logic                flag_wr,
    input  logic [3:0]          flag_nzcv,
    input  logic                flush,
    output logic [3:0]          nzcv
);

    typedef struct packed {
        logic                rw;
        logic [1:0]          src;
        logic [ALU_OP_W-1:0] aop;
        logic                m2r;
        logic                mw;
        logic                pc;
        logic                upd;
        logic                lnk;
        logic                cf;
    } ctrl_t;

    logic [3:0] cond;
    logic [7:0] op;
    logic       fwd_wr;
    logic [3:0] eff_nzcv;
    logic       f_n, f_z, f_c, f_v;
    logic       cond_pass;
    logic       needs_flags;
    logic       hazard;
    logic       accept;
    ctrl_t      raw;
    ctrl_t      dec_word;

    logic       out_valid_q, out_valid_d;
    ctrl_t      word_q, word_d;
    logic [3:0] nzcv_q, nzcv_d;
    logic [2:0] pend_q, pend_d;

    assign cond     = opfunc[11:8];
    assign op       = opfunc[7:0];
    assign fwd_wr   = (FWD_EN != 0) && flag_wr;
    assign eff_nzcv = fwd_wr ? flag_nzcv : nzcv_q;
    assign f_n      = eff_nzcv[3];
    assign f_z      = eff_nzcv[2];
    assign f_c      = eff_nzcv[1];
    assign f_v      = eff_nzcv[0];

    always_comb begin
        cond_pass = 1'b1;
        case (cond)
            4'b0000: cond_pass = f_z;
            4'b0001: cond_pass = !f_z;
            4'b0010: cond_pass = f_c;
            4'b0011: cond_pass = !f_c;
            4'b0100: cond_pass = f_n;
            4'b0101: cond_pass = !f_n;
            4'b0110: cond_pass = f_v;
            4'b0111: cond_pass = !f_v;
            4'b1000: cond_pass = f_c && !f_z;
            4'b1001: cond_pass = !f_c || f_z;
            4'b1010: cond_pass = (f_n == f_v);
            4'b1011: cond_pass = (f_n != f_v);
            4'b1100: cond_pass = !f_z && (f_n == f_v);
            4'b1101: cond_pass = f_z || (f_n != f_v);
            default: cond_pass = 1'b1;
        endcase
    end

    always_comb begin
        raw = '0;
        unique case (1'b1)
            (op[7:5] == 3'b101): begin
                raw.pc  = 1'b1;
                raw.lnk = op[4];
            end
            (op[7:6] == 2'b00): begin
                raw.aop = ALU_OP_W'(op[4:1]);
                raw.src = op[5] ? 2'b01 : 2'b00;
                raw.upd = op[0];
                raw.rw  = !(op[4:3] == 2'b10);
            end
            (op[7:6] == 2'b01): begin
                raw.rw  = op[0];
                raw.mw  = !op[0];
                raw.m2r = 1'b1;
                raw.aop = op[3] ? ALU_OP_W'(4'b0100) : ALU_OP_W'(4'b0010);
                raw.src = op[5] ? 2'b11 : 2'b10;
            end
            default: ;
        endcase
    end

    always_comb begin
        dec_word    = '0;
        dec_word.cf = 1'b1;
        if (cond_pass) dec_word = raw;
    end

    assign needs_flags = (cond < 4'b1110);
    assign hazard = (needs_flags && (pend_q > (fwd_wr ? 3'd1 : 3'd0)))
                 || (raw.upd && (pend_q == 3'(PEND_MAX)) && !flag_wr);
    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        word_d      = word_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            word_d      = dec_word;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign nzcv_d = flag_wr ? flag_nzcv : nzcv_q;

    // A dropped flag-setter will never write back, so release its slot.
    logic       inc, dfl;
    logic [3:0] sum;
    logic [3:0] sub;
    assign inc = accept && cond_pass && raw.upd;
    assign dfl = flush && out_valid_q && !out_ready && word_q.upd;
    assign sum = {1'b0, pend_q} + {3'b000, inc};
    assign sub = {3'b000, flag_wr} + {3'b000, dfl};
    assign pend_d = (sum >= sub) ? 3'(sum - sub) : 3'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            word_q      <= '0;
            nzcv_q      <= NZCV_RST;
            pend_q      <= 3'd0;
        end else begin
            out_valid_q <= out_valid_d;
            word_q      <= word_d;
            nzcv_q      <= nzcv_d;
            pend_q      <= pend_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign reg_write   = word_q.rw;
    assign alu_src     = word_q.src;
    assign alu_op      = word_q.aop;
    assign mem_to_reg  = word_q.m2r;
    assign mem_write   = word_q.mw;
    assign pc_src      = word_q.pc;
    assign update_nzcv = word_q.upd;
    assign link        = word_q.lnk;
    assign cond_fail   = word_q.cf;
    assign nzcv        = nzcv_q;

endmodule

// File: tb/tb_cond_ctrl_pipe.sv
// Scoreboard bench for cond_ctrl_pipe: expected words queued on accept,
// a negedge monitor pops and compares on every output handshake.
module tb_cond_ctrl_pipe;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [11:0] opfunc;
    logic        out_valid, out_ready;
    logic        reg_write;
    logic [1:0]  alu_src;
    logic [3:0]  alu_op;
    logic        mem_to_reg, mem_write, pc_src, update_nzcv, link, cond_fail;
    logic        flag_wr;
    logic [3:0]  flag_nzcv;
    logic        flush;
    logic [3:0]  nzcv;

    cond_ctrl_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .opfunc(opfunc),
        .out_valid(out_valid), .out_ready(out_ready),
        .reg_write(reg_write), .alu_src(alu_src), .alu_op(alu_op),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .pc_src(pc_src),
        .update_nzcv(update_nzcv), .link(link), .cond_fail(cond_fail),
        .flag_wr(flag_wr), .flag_nzcv(flag_nzcv), .flush(flush), .nzcv(nzcv)
    );

    // {rw, src[1:0], alu_op[3:0], m2r, mw, pc, upd, link, cf}
    localparam logic [12:0] W_E0B = 13'b1_00_0101_0_0_0_1_0_0;
    localparam logic [12:0] W_BR  = 13'b0_00_0000_0_0_1_0_0_0;
    localparam logic [12:0] W_CF  = 13'b0_00_0000_0_0_0_0_0_1;
    localparam logic [12:0] W_E03 = 13'b1_00_0001_0_0_0_1_0_0;
    localparam logic [12:0] W_E2B = 13'b1_01_0101_0_0_0_1_0_0;
    localparam logic [12:0] W_E11 = 13'b0_00_1000_0_0_0_1_0_0;
    localparam logic [12:0] W_E68 = 13'b0_11_0100_1_1_0_0_0_0;
    localparam logic [12:0] W_E41 = 13'b1_10_0010_1_0_0_0_0_0;
    localparam logic [12:0] W_EB0 = 13'b0_00_0000_0_0_1_0_1_0;
    localparam logic [12:0] W_NUL = 13'b0;
    localparam logic [12:0] W_C02 = 13'b1_00_0001_0_0_0_0_0_0;

    int checks = 0;
    int errors = 0;
    logic [12:0] expq[$];
    logic [12:0] word;

    assign word = {reg_write, alu_src, alu_op, mem_to_reg, mem_write,
                   pc_src, update_nzcv, link, cond_fail};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && (out_ready || flush)) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out got %h want none", word);
            end else begin
                logic [12:0] e;
                e = expq.pop_front();
                if (out_ready) begin
                    checks++;
                    if (word !== e) begin
                        errors++;
                        $display("FAIL out_word got %h want %h", word, e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [11:0] opf, input logic [12:0] exp);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        opfunc   = opf;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) expq.push_back(exp);
        else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got 0 want 1 op %h", opf);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic pulse_flags(input logic [3:0] f);
        flag_wr   = 1'b1;
        flag_nzcv = f;
        step();
        flag_wr   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; opfunc = '0; out_ready = 1'b1;
        flag_wr = 1'b0; flag_nzcv = '0; flush = 1'b0;
        #12;
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_nzcv", 16'(nzcv), 16'd0);
        chk("rst_word", 16'(word), 16'd0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        step();

        issue(12'hE0B, W_E0B);

        in_valid = 1'b1; opfunc = 12'h0A0;
        @(negedge clk);
        chk("eq_stall0", 16'(in_ready), 16'd0);
        step();
        @(negedge clk);
        chk("eq_stall1", 16'(in_ready), 16'd0);
        step();
        flag_wr = 1'b1; flag_nzcv = 4'b0100;
        @(negedge clk);
        chk("eq_fwd_ready", 16'(in_ready), 16'd1);
        if (in_ready) expq.push_back(W_BR);
        step();
        flag_wr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("nzcv_0100", 16'(nzcv), 16'h4);
        step();

        pulse_flags(4'b0000);
        @(negedge clk);
        chk("nzcv_0000", 16'(nzcv), 16'h0);
        step();
        issue(12'h0A0, W_CF);

        issue(12'hE03, W_E03);
        issue(12'hE2B, W_E2B);
        issue(12'hE11, W_E11);
        in_valid = 1'b1; opfunc = 12'hE0B;
        @(negedge clk);
        chk("pend_full_stall", 16'(in_ready), 16'd0);
        step();
        flag_wr = 1'b1; flag_nzcv = 4'b1001;
        @(negedge clk);
        chk("pend_full_fwd", 16'(in_ready), 16'd1);
        if (in_ready) expq.push_back(W_E0B);
        step();
        flag_wr = 1'b0;
        @(negedge clk);
        chk("pend_still_3", 16'(in_ready), 16'd0);
        chk("nzcv_1001", 16'(nzcv), 16'h9);
        step();
        in_valid = 1'b0;
        pulse_flags(4'b0000);
        pulse_flags(4'b0000);
        pulse_flags(4'b0000);

        in_valid = 1'b1; opfunc = 12'h1A0;
        @(negedge clk);
        chk("drained_ready", 16'(in_ready), 16'd1);
        step();
        in_valid = 1'b0;
        expq.push_back(W_BR);
        issue(12'hE68, W_E68);
        issue(12'hE41, W_E41);
        issue(12'hEB0, W_EB0);
        issue(12'hEC0, W_NUL);
        issue(12'hC02, W_C02);
        issue(12'hB02, W_CF);
        step();

        out_ready = 1'b0;
        issue(12'hE0B, W_E0B);
        @(negedge clk);
        chk("hold_valid", 16'(out_valid), 16'd1);
        chk("hold_word0", 16'(word), 16'(W_E0B));
        step();
        @(negedge clk);
        chk("hold_word1", 16'(word), 16'(W_E0B));
        flush = 1'b1;
        chk("flush_no_ready", 16'(in_ready), 16'd0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", 16'(out_valid), 16'd0);
        step();
        out_ready = 1'b1;
        in_valid = 1'b1; opfunc = 12'h1A0;
        @(negedge clk);
        chk("flush_pend_dec", 16'(in_ready), 16'd1);
        step();
        in_valid = 1'b0;
        expq.push_back(W_BR);
        step();

        out_ready = 1'b0;
        issue(12'hE03, W_E03);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 16'(out_valid), 16'd0);
        chk("mid_rst_word", 16'(word), 16'd0);
        chk("mid_rst_nzcv", 16'(nzcv), 16'd0);
        expq.delete();
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1; opfunc = 12'h0A0;
        @(negedge clk);
        chk("mid_rst_ready", 16'(in_ready), 16'd1);
        step();
        in_valid = 1'b0;
        expq.push_back(W_CF);
        repeat (4) step();
        chk("queue_empty", 16'(expq.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
